// File: rtl/ocp_initiator.sv
// ocp_initiator: single-outstanding master for the 8-bit MCmd/SResp register bus.
// Turns one host command into one bus transaction and returns read data or
// write completion on a valid/ready response port. Every wait for the slave
// is bounded by a saturating timeout counter so a dead slave cannot stall the host.
module ocp_initiator #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_error,
  output logic       busy,
  output logic [2:0] MCmd,
  output logic [7:0] MAddr,
  output logic [7:0] MData,
  input  logic       SCmdAccept,
  input  logic [7:0] SData,
  input  logic [1:0] SResp
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_inc;
  logic            to_expired;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    if (v == {TO_W{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  // Next counter value and whether this edge is the last one allowed to wait.
  always_comb begin
    to_cnt_inc = sat_inc(to_cnt);
    to_expired = (to_cnt_inc >= TO_LIMIT);
  end

  // Handshake outputs are pure state decodes so the host sees them without delay.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
  end

  // Transaction sequencer; all bus and response outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      MCmd      <= MCMD_IDLE;
      MAddr     <= 8'h00;
      MData     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_error <= 1'b0;
      to_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            MAddr  <= cmd_addr;
            MData  <= cmd_wdata;
            MCmd   <= cmd_write ? MCMD_WR : MCMD_RD;
            to_cnt <= '0;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          // Accept wins over a timeout landing on the same edge.
          if (SCmdAccept) begin
            MCmd <= MCMD_IDLE;
            if (MCmd == MCMD_WR) begin
              // Posted write: complete immediately, no SResp expected.
              rsp_valid <= 1'b1;
              rsp_data  <= 8'h00;
              rsp_error <= 1'b0;
              state     <= S_RESP;
            end else begin
              to_cnt <= '0;
              state  <= S_WAIT_RESP;
            end
          end else if (to_expired) begin
            MCmd      <= MCMD_IDLE;
            rsp_valid <= 1'b1;
            rsp_data  <= 8'h00;
            rsp_error <= 1'b1;
            state     <= S_RESP;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        S_WAIT_RESP: begin
          if (SResp != SRESP_NULL) begin
            rsp_valid <= 1'b1;
            rsp_data  <= SData;
            rsp_error <= (SResp != SRESP_DVA);
            state     <= S_RESP;
          end else if (to_expired) begin
            rsp_valid <= 1'b1;
            rsp_data  <= 8'h00;
            rsp_error <= 1'b1;
            state     <= S_RESP;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          MCmd  <= MCMD_IDLE;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ocp_initiator.sv
// Directed bench for ocp_initiator with a small behavioural slave.
module tb_ocp_initiator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_error, busy;
  logic [7:0] rsp_data;
  logic [2:0] MCmd;
  logic [7:0] MAddr, MData;
  logic       SCmdAccept;
  logic [7:0] SData;
  logic [1:0] SResp;

  int errors = 0;
  int checks = 0;

  // Slave behaviour: 0 = DVA with memory data, 1 = never respond, 2 = ERR with 3C
  int   resp_mode = 0;
  logic stray     = 1'b0;
  logic [7:0] mem [256];
  logic [255:0] written;

  ocp_initiator #(.TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .busy(busy),
    .MCmd(MCmd), .MAddr(MAddr), .MData(MData),
    .SCmdAccept(SCmdAccept), .SData(SData), .SResp(SResp)
  );

  always #5 clk = ~clk;

  // Zero-wait slave: responds one cycle after accepting a read; unwritten addresses read 44.
  always @(posedge clk) begin
    SResp <= 2'b00;
    SData <= 8'h00;
    if (MCmd == 3'b001 && SCmdAccept) begin
      mem[MAddr]     <= MData;
      written[MAddr] <= 1'b1;
    end
    if (MCmd == 3'b010 && SCmdAccept) begin
      if (resp_mode == 0) begin
        SResp <= 2'b01;
        SData <= written[MAddr] ? mem[MAddr] : 8'h44;
      end else if (resp_mode == 2) begin
        SResp <= 2'b11;
        SData <= 8'h3C;
      end
    end
    if (stray) begin
      SResp <= 2'b01;
      SData <= 8'h99;
    end
  end

  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_handshake();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (MCmd !== 3'b000 || MAddr !== 8'h00 || MData !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: MCmd=%b MAddr=%h MData=%h, required 000/00/00", MCmd, MAddr, MData);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b data=%h err=%b, required 0/00/0", rsp_valid, rsp_data, rsp_error);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_zero_wait();
    send_cmd(1'b0, 8'h00, 8'hFF);
    @(negedge clk);  // cycle N+1
    checks++;
    if (MCmd !== 3'b010 || MAddr !== 8'h00) begin
      errors++;
      $display("FAIL read_cmd: MCmd=%b MAddr=%h, required 010/00", MCmd, MAddr);
    end
    @(negedge clk);  // cycle N+2
    checks++;
    if (MCmd !== 3'b000 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_n2: MCmd=%b rsp_valid=%b, required 000/0", MCmd, rsp_valid);
    end
    @(negedge clk);  // cycle N+3
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h44 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL read_rsp: valid=%b data=%h err=%b, required 1/44/0", rsp_valid, rsp_data, rsp_error);
    end
    rsp_handshake();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_done: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_write_then_read();
    send_cmd(1'b1, 8'h10, 8'hA5);
    @(negedge clk);  // cycle N+1
    checks++;
    if (MCmd !== 3'b001 || MAddr !== 8'h10 || MData !== 8'hA5) begin
      errors++;
      $display("FAIL write_cmd: MCmd=%b MAddr=%h MData=%h, required 001/10/A5", MCmd, MAddr, MData);
    end
    @(negedge clk);  // cycle N+2
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_error !== 1'b0 || MCmd !== 3'b000) begin
      errors++;
      $display("FAIL write_rsp: valid=%b data=%h err=%b MCmd=%b, required 1/00/0/000",
               rsp_valid, rsp_data, rsp_error, MCmd);
    end
    rsp_handshake();
    send_cmd(1'b0, 8'h10, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL readback: valid=%b data=%h err=%b, required 1/A5/0", rsp_valid, rsp_data, rsp_error);
    end
    rsp_handshake();
  endtask

  task automatic test_accept_stall();
    int stable_cycles;
    stable_cycles = 0;
    SCmdAccept = 1'b0;
    send_cmd(1'b1, 8'h20, 8'h5A);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (MCmd === 3'b001 && MAddr === 8'h20 && MData === 8'h5A && !rsp_valid) stable_cycles++;
      if (i == 6) SCmdAccept = 1'b1;
    end
    checks++;
    if (stable_cycles != 6) begin
      errors++;
      $display("FAIL stall_stable: stable cycles=%0d, required 6", stable_cycles);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || MCmd !== 3'b000) begin
      errors++;
      $display("FAIL stall_done: valid=%b err=%b MCmd=%b, required 1/0/000", rsp_valid, rsp_error, MCmd);
    end
    rsp_handshake();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    resp_mode = 1;
    send_cmd(1'b0, 8'h40, 8'h00);
    while (n < 20 && rsp_valid !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    // Accept at edge N+1, 8 empty SResp edges, valid seen at the 10th negedge.
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL timeout_latency: negedges=%0d, required 10", n);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL timeout_rsp: valid=%b err=%b data=%h, required 1/1/00", rsp_valid, rsp_error, rsp_data);
    end
    rsp_handshake();
    resp_mode = 0;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL stray_resp[%0d]: cmd_ready=%b rsp_valid=%b busy=%b, required 1/0/0",
                 i, cmd_ready, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_error_backpressure();
    resp_mode = 2;
    send_cmd(1'b0, 8'h30, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 8'h3C) begin
      errors++;
      $display("FAIL err_rsp: valid=%b err=%b data=%h, required 1/1/3C", rsp_valid, rsp_error, rsp_data);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || rsp_error !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL err_hold[%0d]: valid=%b data=%h err=%b cmd_ready=%b, required 1/3C/1/0",
                 i, rsp_valid, rsp_data, rsp_error, cmd_ready);
      end
    end
    rsp_handshake();
    resp_mode = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_release: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_transaction();
    SCmdAccept = 1'b0;
    send_cmd(1'b0, 8'h55, 8'h00);
    @(negedge clk);
    checks++;
    if (MCmd !== 3'b010) begin
      errors++;
      $display("FAIL mid_req: MCmd=%b, required 010", MCmd);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (MCmd !== 3'b000 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: MCmd=%b rsp_valid=%b busy=%b cmd_ready=%b, required 000/0/0/1",
               MCmd, rsp_valid, busy, cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    SCmdAccept = 1'b1;
    send_cmd(1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h44 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_read: valid=%b data=%h err=%b, required 1/44/0", rsp_valid, rsp_data, rsp_error);
    end
    rsp_handshake();
  endtask

  initial begin
    written    = '0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 8'h00;
    cmd_wdata  = 8'h00;
    rsp_ready  = 1'b0;
    SCmdAccept = 1'b1;
    test_reset();
    test_read_zero_wait();
    test_write_then_read();
    test_accept_stall();
    test_timeout();
    test_error_backpressure();
    test_reset_mid_transaction();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ocp_initiator.md
Name: ocp_initiator

Overview:
- Bus initiator (master) for the 8-bit MCmd/MAddr/MData/SCmdAccept/SData/SResp register bus used by the debugger and other slave peripherals.
- Converts single host commands into one bus transaction each. Host sources include the UART command parser and the bring-up sequencer.
- Returns read data or write completion to the host through a valid/ready response port.
- Guards every transaction with a timeout so a dead slave cannot hang the host.

Parameters:
- TIMEOUT, 255, maximum cycles spent waiting in REQ for accept, or in WAIT_RESP for a read response. Legal range is 1..255.
- TO_W, 8, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command present
cmd_ready  out  1  initiator can take a command (high only in IDLE)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  8  bus address
cmd_wdata  in  8  write data (ignored for reads)
rsp_valid  out  1  response present; held until rsp_ready
rsp_ready  in  1  host takes the response
rsp_data  out  8  read data; 8'h00 for writes and timeouts
rsp_error  out  1  1 = timeout, or SResp FAIL/ERR
busy  out  1  state != IDLE
MCmd  out  3  3'b000 IDLE, 3'b001 WR, 3'b010 RD
MAddr  out  8  bus address
MData  out  8  bus write data
SCmdAccept  in  1  slave accepts the current command
SData  in  8  slave read data, valid when SResp != 00
SResp  in  2  00 NULL, 01 DVA, 10 FAIL, 11 ERR

Behaviour:
- Reset (asynchronous, active-low; clock clk): state=IDLE, MCmd=000, MAddr=00, MData=00, rsp_valid=0, rsp_data=00, rsp_error=0, timeout counter=0. Combinational outputs at reset: cmd_ready=1, busy=0.
- All bus outputs and response outputs are registered. cmd_ready and busy are decoded from state.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at an edge: latch addr and wdata; drive MCmd=001 (write) or 010 (read) from the next cycle; clear the counter; go to REQ.
- REQ:
  - MCmd, MAddr and MData are held stable until the edge at which SCmdAccept=1 is sampled. MCmd returns to 000 on the following cycle.
  - Write accepted: go to RESP with rsp_valid=1, rsp_data=00, rsp_error=0. Writes are posted; no SResp is expected.
  - Read accepted: go to WAIT_RESP and clear the counter.
  - SResp is ignored while in REQ.
  - If the counter reaches TIMEOUT without accept: MCmd=000, rsp_error=1, rsp_data=00, go to RESP.
- WAIT_RESP:
  - MCmd=000. SResp is sampled every edge.
  - SResp=01: rsp_data=SData, rsp_error=0, go to RESP.
  - SResp=10 or 11: rsp_data=SData, rsp_error=1, go to RESP.
  - SResp=00: increment the counter. On reaching TIMEOUT: rsp_error=1, rsp_data=00, go to RESP.
- RESP:
  - rsp_valid=1, with data and error held stable.
  - On rsp_ready at an edge: rsp_valid=0, go to IDLE.
  - A new command is accepted no earlier than the cycle after the response handshake, so there is at most one outstanding transaction.
- Latency against a zero-wait slave (SCmdAccept tied high, SResp one cycle after the command):
  - Write: cmd handshake edge N, MCmd=WR during cycle N+1, rsp_valid from N+2.
  - Read: MCmd=RD during cycle N+1, SResp=DVA during cycle N+2, rsp_valid from N+3.
- Counter: saturates and never wraps. TIMEOUT is counted in clk cycles from entry into REQ or WAIT_RESP.
- A late SResp or SCmdAccept arriving outside the expected state (IDLE, RESP, or after a timeout) is ignored.
- Asserting reset mid-transaction forces MCmd=000 and IDLE immediately; any pending response is discarded.

Test Plan:
- Zero-wait slave model; read cmd_addr=00 while the slave returns 44 -> MCmd=010 for exactly 1 cycle; rsp_valid at N+3 with rsp_data=44, rsp_error=0.
- Write addr=10, data=A5, then read addr=10 -> write rsp_data=00, rsp_error=0; MData=A5 while MCmd=001; read returns A5.
- SCmdAccept held low for 5 cycles, then high -> MCmd, MAddr and MData stable for 6 cycles; normal completion; no timeout.
- Read with SResp never asserted, TIMEOUT=8 -> rsp_valid 8 cycles after entry into WAIT_RESP, rsp_error=1, rsp_data=00. A later stray SResp=01 is ignored and cmd_ready stays 1.
- SResp=11 with SData=3C -> rsp_error=1, rsp_data=3C. Hold rsp_ready low 4 cycles -> rsp_valid and rsp_data stay stable; cmd_ready=0 until after the handshake.
- reset_n pulsed low while MCmd=010 in REQ -> MCmd=000, rsp_valid=0, busy=0 asynchronously. The next command after release completes normally.
